// File: rtl/uart_pkg.sv
// Shared types for the UART frame decoder: FSM states, error codes and a
// width helper that never returns zero.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CSUM,
    OUTPUT
  } state_t;

  typedef enum logic [1:0] {
    E_LINE    = 2'd0,
    E_LEN     = 2'd1,
    E_CSUM    = 2'd2,
    E_TIMEOUT = 2'd3
  } err_code_t;

  // Address/counter width that stays at least 1 bit for degenerate sizes.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port and
// one asynchronous read port.
module uart_frame_buf
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = clog2_min1(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: the storage is cleared on reset so a replayed frame can never expose
  // bytes left over from an aborted one; drop this reset if area matters more.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_decoder.sv
// Byte-level framer behind a UART receiver: SYNC, LEN, payload, XOR checksum,
// then replays good payloads as a valid/ready stream with a last flag.
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rx_err,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       drop
);

  localparam int             LW        = $clog2(MAX_LEN + 1);
  localparam int             AW        = clog2_min1(MAX_LEN);
  localparam int             TW        = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  T_RELOAD  = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  state_t        state, state_next;
  logic [LW-1:0] len, wr_idx, rd_idx;
  logic [7:0]    csum;
  logic [TW-1:0] timer;
  logic [7:0]    buf_rd;
  err_code_t     err_q, err_evt_code;
  logic          err_evt, in_frame, expired, handshake, last_beat, buf_wr;

  assign in_frame  = state inside {LEN, PAYLOAD, CSUM};
  // The timer never sits at 0 inside a frame, so the 1 -> 0 step is the expiry.
  assign expired   = (TIMEOUT_CYCLES != 0) && in_frame && (timer == TW'(1));
  assign handshake = (state == OUTPUT) && out_ready;
  assign last_beat = (rd_idx == len - LW'(1));
  assign buf_wr    = (state == PAYLOAD) && rx_done && !rx_err;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= HUNT;
    else       state <= state_next;
  end

  // NOTE: every variable written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_next   = state;
    err_evt      = 1'b0;
    err_evt_code = E_LINE;
    unique case (state)
      HUNT: begin
        if (rx_done && rx_data == SYNC_BYTE) state_next = LEN;
      end
      LEN, PAYLOAD, CSUM: begin
        if (rx_err) begin
          state_next   = HUNT;
          err_evt      = 1'b1;
          err_evt_code = E_LINE;
        end else if (rx_done) begin
          if (state == LEN) begin
            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
              state_next   = HUNT;
              err_evt      = 1'b1;
              err_evt_code = E_LEN;
            end else begin
              state_next = PAYLOAD;
            end
          end else if (state == PAYLOAD) begin
            if (wr_idx == len - LW'(1)) state_next = CSUM;
          end else if (rx_data == csum) begin
            state_next = OUTPUT;
          end else begin
            state_next   = HUNT;
            err_evt      = 1'b1;
            err_evt_code = E_CSUM;
          end
        end else if (expired) begin
          state_next   = HUNT;
          err_evt      = 1'b1;
          err_evt_code = E_TIMEOUT;
        end
      end
      OUTPUT: begin
        if (handshake && last_beat) state_next = HUNT;
      end
      default: state_next = HUNT;
    endcase
  end

  always_comb begin
    out_valid = (state == OUTPUT);
    out_last  = out_valid && last_beat;
    out_data  = out_valid ? buf_rd : 8'd0;
    busy      = (state != HUNT);
    frame_ok  = out_valid && out_ready && last_beat;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      len       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      csum      <= '0;
      timer     <= '0;
      frame_err <= 1'b0;
      err_q     <= E_LINE;
      drop      <= 1'b0;
    end else begin
      frame_err <= err_evt;
      if (err_evt) err_q <= err_evt_code;
      drop <= (state == OUTPUT) && (rx_done || rx_err);

      if (state == HUNT && state_next == LEN) begin
        timer <= T_RELOAD;
      end else if (in_frame) begin
        if (rx_done)              timer <= T_RELOAD;
        else if (timer != '0)     timer <= timer - TW'(1);
      end

      if (state == LEN && state_next == PAYLOAD) begin
        len    <= rx_data[LW-1:0];
        csum   <= rx_data;
        wr_idx <= '0;
      end

      if (buf_wr) begin
        csum   <= csum ^ rx_data;
        wr_idx <= wr_idx + LW'(1);
      end

      if (state == CSUM && state_next == OUTPUT) rd_idx <= '0;
      else if (handshake)                        rd_idx <= rd_idx + LW'(1);
    end
  end

  assign err_code = err_q;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (buf_wr),
    .wr_addr (wr_idx[AW-1:0]),
    .wr_data (rx_data),
    .rd_addr (rd_idx[AW-1:0]),
    .rd_data (buf_rd)
  );

endmodule
